// File: rtl/core_column_readout_pkg.sv
// Shared types and word layout for the column readout block.
package core_column_readout_pkg;

   localparam int unsigned NCORES   = 8;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned TRIGID_W = 5;
   localparam int unsigned CIDX_W   = $clog2(NCORES);
   localparam int unsigned WORD_W   = 1 + CIDX_W + DATA_W;

   typedef enum logic [2:0] {
      StIdle,
      StHeader,
      StScan,
      StRead,
      StCapt,
      StDone
   } state_e;

   // One output FIFO entry: header flag, source core index, payload.
   typedef struct packed {
      logic              hdr;
      logic [CIDX_W-1:0] cidx;
      logic [DATA_W-1:0] data;
   } out_word_t;

   // Event header: flag set, core index zero, trigger ID zero-extended into the payload.
   function automatic out_word_t make_header(input logic [TRIGID_W-1:0] trigid);
      out_word_t w;
      w.hdr  = 1'b1;
      w.cidx = '0;
      w.data = DATA_W'(trigid);
      return w;
   endfunction

endpackage

// File: rtl/core_column_readout_if.sv
// Signal bundle between the column readout, its cores, requester and data merger.
interface core_column_readout_if;
   import core_column_readout_pkg::*;

   logic                     ReadReq;
   logic [TRIGID_W-1:0]      TrigIdReq;
   logic                     ReadAck;
   logic [7:0]               HitCnt;
   logic [NCORES-1:0]        CoreToken;
   logic [NCORES-1:0]        CoreRead;
   logic [TRIGID_W-1:0]      CoreTrigId;
   logic [NCORES*DATA_W-1:0] CoreData;
   logic [WORD_W-1:0]        OutData;
   logic                     OutValid;
   logic                     OutReady;

   // Environment side: requester, cores and merger.
   modport master (
      output ReadReq, TrigIdReq, CoreToken, CoreData, OutReady,
      input  ReadAck, HitCnt, CoreRead, CoreTrigId, OutData, OutValid
   );

   // Readout block side.
   modport slave (
      input  ReadReq, TrigIdReq, CoreToken, CoreData, OutReady,
      output ReadAck, HitCnt, CoreRead, CoreTrigId, OutData, OutValid
   );

endinterface

// File: rtl/core_column_readout_fifo.sv
// Synchronous first-word-fall-through FIFO with full, empty and free-slot count.
module core_column_readout_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] free
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign full     = (cnt_q == FullCnt);
   assign empty    = (cnt_q == '0);
   assign free     = FullCnt - cnt_q;
   assign pop_data = empty ? '0 : mem_q[rd_q];

   // Storage array, no reset needed since reads are gated by empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q] <= push_data;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/core_column_readout.sv
// Drains one column of cores for a trigger ID into an output FIFO behind an event header.
module core_column_readout
   import core_column_readout_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input logic                 Clk,
   input logic                 Reset_b,
   core_column_readout_if.slave bus
);

   localparam int unsigned FREE_W = $clog2(FIFO_DEPTH) + 1;

   state_e              state_q, state_d;
   logic [TRIGID_W-1:0] trig_q;
   logic [CIDX_W-1:0]   cidx_q;
   logic [7:0]          hit_q;

   logic                found;
   logic [CIDX_W-1:0]   enc_idx;
   logic [DATA_W-1:0]   sel_data;
   logic [NCORES-1:0]   read_onehot;

   logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [FREE_W-1:0]   fifo_free;
   out_word_t           push_word;
   logic [WORD_W-1:0]   head_word;

   // Lowest asserted token wins, so the top core always has priority.
   always_comb begin
      found   = 1'b0;
      enc_idx = '0;
      for (int k = int'(NCORES) - 1; k >= 0; k--) begin
         if (bus.CoreToken[k]) begin
            found   = 1'b1;
            enc_idx = CIDX_W'(k);
         end
      end
   end

   assign sel_data = bus.CoreData[cidx_q*DATA_W +: DATA_W];

   // State register.
   always_ff @(posedge Clk or negedge Reset_b) begin
      if (!Reset_b) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; READ is only entered with a free slot, which CAPT later consumes.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (bus.ReadReq) state_d = StHeader;
         StHeader: if (!fifo_full) state_d = StScan;
         StScan: begin
            if (!found) begin
               state_d = StDone;
            end else if (fifo_free != '0) begin
               state_d = StRead;
            end
         end
         StRead:   state_d = StCapt;
         StCapt:   state_d = StScan;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // FSM outputs: core strobe, FIFO push and acknowledge.
   always_comb begin
      fifo_push   = 1'b0;
      push_word   = '0;
      read_onehot = '0;
      bus.ReadAck = 1'b0;
      unique case (state_q)
         StHeader: begin
            if (!fifo_full) begin
               fifo_push = 1'b1;
               push_word = make_header(trig_q);
            end
         end
         StRead: read_onehot[cidx_q] = 1'b1;
         StCapt: begin
            fifo_push = 1'b1;
            push_word = '{hdr: 1'b0, cidx: cidx_q, data: sel_data};
         end
         StDone:  bus.ReadAck = 1'b1;
         default: ;
      endcase
   end

   // Trigger ID capture, selected core index and saturating hit counter.
   always_ff @(posedge Clk or negedge Reset_b) begin
      if (!Reset_b) begin
         trig_q <= '0;
         cidx_q <= '0;
         hit_q  <= '0;
      end else begin
         if (state_q == StIdle && bus.ReadReq) begin
            trig_q <= bus.TrigIdReq;
            hit_q  <= '0;
         end
         if (state_q == StScan && found && fifo_free != '0) begin
            cidx_q <= enc_idx;
         end
         if (state_q == StCapt && hit_q != 8'hFF) begin
            hit_q <= hit_q + 8'd1;
         end
      end
   end

   assign fifo_pop       = bus.OutReady & ~fifo_empty;
   assign bus.CoreRead   = read_onehot;
   assign bus.CoreTrigId = trig_q;
   assign bus.HitCnt     = hit_q;
   assign bus.OutValid   = ~fifo_empty;
   assign bus.OutData    = head_word;

   core_column_readout_fifo #(
      .WIDTH(WORD_W),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (Clk),
      .rst_n    (Reset_b),
      .push     (fifo_push),
      .push_data(push_word),
      .pop      (fifo_pop),
      .pop_data (head_word),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .free     (fifo_free)
   );

endmodule
